// File: rtl/mem_arbiter.sv
// Purpose: time-multiplexes a single-port RAM between instruction fetch and data access.
// Latency: LAT cycles per access (strobes t+1..t+LAT, hit at t+LAT), one IDLE cycle between accesses.
// Backpressure: requests are held until a hit pulses; halt blocks new grants but lets an in-flight access finish.
module mem_arbiter #(
  parameter int LAT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_t;

  // Counter reload: an access spends LAT cycles, counting LAT-1 down to 0.
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        last_d_q;   // previous completed access was a data access
  logic [31:0] addr_q;
  logic [31:0] store_q;
  logic        wr_q;       // latched access type: 1 = data write

  logic dreq;
  logic pick_dacc;
  logic pick_iacc;
  logic done;

  // Grant selection in IDLE: data first, except a fetch wins once right after a data access.
  always_comb begin
    dreq      = dREN | dWEN;
    pick_dacc = 1'b0;
    pick_iacc = 1'b0;
    if (state_q == IDLE && !halt) begin
      pick_dacc = dreq && !(last_d_q && iREN);
      pick_iacc = !pick_dacc && iREN;
    end
    done = (state_q != IDLE) && (cnt_q == 4'd0);
  end

  // Arbitration FSM: latch the winning request, count down the access, return to IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      last_d_q <= 1'b0;
      addr_q   <= 32'd0;
      store_q  <= 32'd0;
      wr_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_dacc) begin
            state_q <= DACC;
            addr_q  <= daddr;
            store_q <= dstore;
            wr_q    <= dWEN;      // simultaneous read+write is treated as a write
            cnt_q   <= CNT_INIT;
          end else if (pick_iacc) begin
            state_q <= IACC;
            addr_q  <= iaddr;
            store_q <= dstore;
            wr_q    <= 1'b0;
            cnt_q   <= CNT_INIT;
          end
        end
        IACC, DACC: begin
          if (cnt_q == 4'd0) begin
            state_q  <= IDLE;
            last_d_q <= (state_q == DACC);
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM strobes and hits decode directly from registered state, so they follow the access exactly.
  always_comb begin
    ramREN   = (state_q == IACC) || (state_q == DACC && !wr_q);
    ramWEN   = (state_q == DACC) && wr_q;
    ramaddr  = addr_q;
    ramstore = store_q;
    ihit     = done && (state_q == IACC);
    dhit     = done && (state_q == DACC);
    iload    = ihit ? ramload : 32'd0;
    dload    = dhit ? ramload : 32'd0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (LAT=2,3,1) share one stimulus stream.
// Inputs change 1ns after the rising edge; outputs are checked 2ns after the edge.
// Each section only checks the instance whose latency it targets.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST, halt, iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;

  logic        ihit2, dhit2, ramREN2, ramWEN2;
  logic [31:0] iload2, dload2, ramaddr2, ramstore2;
  logic        ihit3, dhit3, ramREN3, ramWEN3;
  logic [31:0] iload3, dload3, ramaddr3, ramstore3;
  logic        ihit1, dhit1, ramREN1, ramWEN1;
  logic [31:0] iload1, dload1, ramaddr1, ramstore1;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.LAT(2)) u2 (
    .CLK(CLK), .RST(RST), .halt(halt), .iREN(iREN), .iaddr(iaddr),
    .ihit(ihit2), .iload(iload2), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .dhit(dhit2), .dload(dload2), .ramREN(ramREN2),
    .ramWEN(ramWEN2), .ramaddr(ramaddr2), .ramstore(ramstore2), .ramload(ramload)
  );

  mem_arbiter #(.LAT(3)) u3 (
    .CLK(CLK), .RST(RST), .halt(halt), .iREN(iREN), .iaddr(iaddr),
    .ihit(ihit3), .iload(iload3), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .dhit(dhit3), .dload(dload3), .ramREN(ramREN3),
    .ramWEN(ramWEN3), .ramaddr(ramaddr3), .ramstore(ramstore3), .ramload(ramload)
  );

  mem_arbiter #(.LAT(1)) u1 (
    .CLK(CLK), .RST(RST), .halt(halt), .iREN(iREN), .iaddr(iaddr),
    .ihit(ihit1), .iload(iload1), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .dhit(dhit1), .dload(dload1), .ramREN(ramREN1),
    .ramWEN(ramWEN1), .ramaddr(ramaddr1), .ramstore(ramstore1), .ramload(ramload)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Let combinational outputs settle before checking.
  task automatic settle();
    #1;
  endtask

  initial begin
    RST = 1'b1; halt = 1'b0; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'h100; daddr = 32'h0; dstore = 32'h0; ramload = 32'hA5A5_0001;

    // ---- Reset with iREN held (LAT=2) ----
    cyc(); cyc(); settle();
    chk("rst_ramREN",   {31'd0, ramREN2}, 32'd0);
    chk("rst_ramWEN",   {31'd0, ramWEN2}, 32'd0);
    chk("rst_ihit",     {31'd0, ihit2},   32'd0);
    chk("rst_dhit",     {31'd0, dhit2},   32'd0);
    chk("rst_ramaddr",  ramaddr2,  32'd0);
    chk("rst_ramstore", ramstore2, 32'd0);
    chk("rst_iload",    iload2,    32'd0);
    chk("rst_dload",    dload2,    32'd0);

    RST = 1'b0;                       // cycle t: IDLE sees the fetch
    settle();
    chk("t0_ramREN", {31'd0, ramREN2}, 32'd0);
    cyc(); settle();                  // t+1
    chk("t1_ramREN",  {31'd0, ramREN2}, 32'd1);
    chk("t1_ramaddr", ramaddr2, 32'h100);
    chk("t1_ihit",    {31'd0, ihit2},   32'd0);
    chk("t1_iload",   iload2, 32'd0);
    cyc(); settle();                  // t+2
    chk("t2_ramREN", {31'd0, ramREN2}, 32'd1);
    chk("t2_ihit",   {31'd0, ihit2},   32'd1);
    chk("t2_iload",  iload2, 32'hA5A5_0001);
    iREN = 1'b0;

    // ---- Simultaneous fetch + data read: data first, then alternation ----
    cyc();                            // IDLE, last access was a fetch
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h104; daddr = 32'h40; ramload = 32'hDEADBEEF;
    settle();
    chk("alt_idle_ramREN", {31'd0, ramREN2}, 32'd0);
    cyc(); settle();
    chk("alt_d1_ramaddr", ramaddr2, 32'h40);
    chk("alt_d1_ramREN",  {31'd0, ramREN2}, 32'd1);
    chk("alt_d1_ramWEN",  {31'd0, ramWEN2}, 32'd0);
    cyc(); settle();
    chk("alt_d2_dhit",  {31'd0, dhit2}, 32'd1);
    chk("alt_d2_ihit",  {31'd0, ihit2}, 32'd0);
    chk("alt_d2_dload", dload2, 32'hDEADBEEF);
    cyc(); settle();                  // IDLE: fetch wins this time
    chk("alt_idle2_ramREN", {31'd0, ramREN2}, 32'd0);
    chk("alt_idle2_dhit",   {31'd0, dhit2},   32'd0);
    cyc(); settle();
    chk("alt_i1_ramaddr", ramaddr2, 32'h104);
    chk("alt_i1_ramREN",  {31'd0, ramREN2}, 32'd1);
    cyc(); settle();
    chk("alt_i2_ihit",  {31'd0, ihit2}, 32'd1);
    chk("alt_i2_dhit",  {31'd0, dhit2}, 32'd0);
    chk("alt_i2_iload", iload2, 32'hDEADBEEF);
    cyc(); settle();                  // IDLE: data again
    cyc(); settle();
    chk("alt_d3_ramaddr", ramaddr2, 32'h40);
    cyc(); settle();
    chk("alt_d4_dhit", {31'd0, dhit2}, 32'd1);
    iREN = 1'b0; dREN = 1'b0;

    // ---- Data write with requester changes mid-access ----
    cyc();                            // IDLE
    dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
    cyc(); settle();
    chk("wr1_ramWEN",   {31'd0, ramWEN2}, 32'd1);
    chk("wr1_ramREN",   {31'd0, ramREN2}, 32'd0);
    chk("wr1_ramaddr",  ramaddr2,  32'h80);
    chk("wr1_ramstore", ramstore2, 32'h1234);
    chk("wr1_dhit",     {31'd0, dhit2}, 32'd0);
    dWEN = 1'b0; daddr = 32'h99; dstore = 32'h5678;
    cyc(); settle();
    chk("wr2_ramWEN",   {31'd0, ramWEN2}, 32'd1);
    chk("wr2_ramREN",   {31'd0, ramREN2}, 32'd0);
    chk("wr2_ramaddr",  ramaddr2,  32'h80);
    chk("wr2_ramstore", ramstore2, 32'h1234);
    chk("wr2_dhit",     {31'd0, dhit2}, 32'd1);
    cyc(); settle();
    chk("wr3_ramWEN", {31'd0, ramWEN2}, 32'd0);
    chk("wr3_dhit",   {31'd0, dhit2},   32'd0);

    // ---- halt raised during a fetch ----
    iREN = 1'b1; iaddr = 32'h200;
    cyc();                            // IACC cycle 1
    halt = 1'b1; dREN = 1'b1;
    settle();
    chk("halt_i1_ramREN", {31'd0, ramREN2}, 32'd1);
    chk("halt_i1_ramaddr", ramaddr2, 32'h200);
    cyc(); settle();
    chk("halt_i2_ihit", {31'd0, ihit2}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      chk("halt_idle_ramREN", {31'd0, ramREN2}, 32'd0);
      chk("halt_idle_ramWEN", {31'd0, ramWEN2}, 32'd0);
      chk("halt_idle_hits",   {30'd0, ihit2, dhit2}, 32'd0);
    end

    // ---- LAT=3: reset in first DACC cycle, then full re-grant ----
    halt = 1'b0; iREN = 1'b0; dREN = 1'b0; RST = 1'b1;
    cyc();
    RST = 1'b0; dREN = 1'b1; daddr = 32'h300; ramload = 32'hCAFE_0003;
    cyc(); settle();                  // first DACC cycle
    chk("l3_d1_ramREN", {31'd0, ramREN3}, 32'd1);
    chk("l3_d1_dhit",   {31'd0, dhit3},   32'd0);
    RST = 1'b1;
    cyc();
    RST = 1'b0;                       // IDLE again, request still pending
    settle();
    chk("l3_abort_ramREN", {31'd0, ramREN3}, 32'd0);
    chk("l3_abort_ramWEN", {31'd0, ramWEN3}, 32'd0);
    chk("l3_abort_dhit",   {31'd0, dhit3},   32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      chk("l3_re_ramREN", {31'd0, ramREN3}, 32'd1);
      chk("l3_re_dhit",   {31'd0, dhit3}, (i == 2) ? 32'd1 : 32'd0);
    end
    chk("l3_re_dload", dload3, 32'hCAFE_0003);
    dREN = 1'b0;

    // ---- LAT=1: continuous fetch hits every second cycle ----
    cyc();
    RST = 1'b1; iREN = 1'b1; iaddr = 32'h400; ramload = 32'h0000_0401;
    cyc();
    RST = 1'b0;                       // IDLE, grant decided this cycle
    for (int i = 0; i < 4; i++) begin
      cyc(); settle();
      chk("l1_ramREN", {31'd0, ramREN1}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("l1_ihit",   {31'd0, ihit1},   (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    chk("l1_ramaddr", ramaddr1, 32'h400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single-port unified RAM between the datapath's instruction-fetch and data-access requests.
- Grants one requester at a time and times each access with a fixed-latency counter.
- Returns the RAM's read data and a one-cycle hit to the granted side.
- Sits between the datapath cache interface (ihit/dhit side) and the RAM model.

Parameters:
- LAT, 2, RAM access latency in cycles (legal range 1..15); every access occupies exactly LAT cycles.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- halt  in  1  processor halted; no new grants once asserted
- iREN  in  1  instruction fetch request
- iaddr  in  32  fetch word address
- ihit  out  1  fetch complete; iload valid this cycle
- iload  out  32  fetched instruction
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  write data
- dhit  out  1  data access complete; dload valid on reads
- dload  out  32  read data
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data; valid in the last access cycle

Behaviour:
- Clocking and reset:
  - One clock CLK, all state updates on the rising edge.
  - Reset is synchronous and active-high (RST).
  - Reset values: state=IDLE, cnt=0, last_d=0, latched addr/store/type=0, ramREN=ramWEN=0, ramaddr=ramstore=0, ihit=dhit=0.
- States: IDLE, IACC, DACC.
- Grant decision, made in IDLE when halt=0:
  - dreq = dREN|dWEN.
  - dreq & !(last_d & iREN) -> DACC.
  - else iREN -> IACC.
  - else stay IDLE.
  - Data has priority, but after a completed data access a pending fetch wins once. This prevents fetch starvation.
  - halt=1 in IDLE: no grant, remain IDLE.
- On grant:
  - Latch address (iaddr or daddr), dstore and access type.
  - dWEN&dREN together is treated as a write.
  - Load cnt=LAT-1.
- Access states:
  - ramREN (read/fetch) or ramWEN (write) is high for every cycle in IACC/DACC.
  - ramaddr/ramstore are driven from the latched values, so later requester changes have no effect.
  - cnt decrements each cycle. When cnt==0:
    - hit is asserted combinationally that cycle: ihit in IACC, dhit in DACC.
    - load output = ramload (pass-through).
    - Next state is IDLE; last_d := (state==DACC).
- Outputs outside the final access cycle:
  - ihit/dhit=0, iload/dload=0.
  - ramREN/ramWEN=0 in IDLE.
- Latency: request seen in IDLE at cycle t -> strobes high t+1..t+LAT, hit at t+LAT, earliest next grant decided at t+LAT+1. Minimum spacing between hits is LAT+1 cycles.
- Requester drops request mid-access: the access still completes and the hit still pulses.
- halt asserted mid-access: the in-flight access completes normally; no further grants.
- RST mid-access: strobes drop at that edge and state returns to IDLE. No hit is issued for the aborted access.
- Strobes and hit are mutually exclusive between sides; ihit&dhit never both 1.

Test Plan:
- Reset with iREN=1 held, LAT=2 -> all outputs 0 during RST. After RST falls at cycle t: ramREN=1 cycles t+1,t+2, ramaddr=iaddr, ihit=1 only at t+2 with iload=ramload.
- iREN=1 and dREN=1 simultaneously from IDLE, daddr=0x40, ramload=0xDEADBEEF -> DACC granted first, dhit with dload=0xDEADBEEF. Next grant is IACC even though dREN is still high; then DACC again (alternation).
- dWEN=1, daddr=0x80, dstore=0x1234; change daddr/dstore mid-access -> ramWEN held LAT cycles with ramaddr=0x80, ramstore=0x1234; dhit=1 last cycle; ramREN=0 throughout.
- halt=1 raised during an IACC -> fetch completes with ihit. Afterwards ramREN=ramWEN=0 and no hits while iREN/dREN stay high.
- RST=1 in first cycle of DACC (LAT=3) -> next cycle IDLE, strobes 0, no dhit. A request after RST falls is re-granted with full LAT latency.
- LAT=1, continuous iREN -> ihit every 2nd cycle, ramREN pattern 1,0,1,0 aligned to ihit.
